// File: rtl/datapath_param.sv
// Parametrised accumulator datapath: AR/DR/PC/IR/AC, a small general
// register file, a shared bus mux, an ALU with registered Z/N/C flags and
// a multi-cycle shift-add multiplier with a busy/done handshake.
module datapath_param #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 4,
    parameter int REG_AW = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  dram_in,
    input  logic [WIDTH-1:0]  iram_in,
    input  logic [3:0]        bus_sel,
    input  logic [REG_AW-1:0] reg_sel,
    input  logic              ld_ar,
    input  logic              ld_dr,
    input  logic              ld_r,
    input  logic              ld_ac,
    input  logic              ld_ir,
    input  logic              ld_pc,
    input  logic              inc_pc,
    input  logic              alu_en,
    input  logic [2:0]        alu_op,
    input  logic              mul_start,
    output logic [WIDTH-1:0]  bus_out,
    output logic [WIDTH-1:0]  addr_out,
    output logic [WIDTH-1:0]  pc_addr,
    output logic [WIDTH-1:0]  ir_out,
    output logic [2:0]        flags,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW     = $clog2(WIDTH + 1);
    // The file is sized to the full select range so any reg_sel indexes
    // a real entry; entries at NREGS and above are never written.
    localparam int RDEPTH = 2 ** REG_AW;

    logic [WIDTH-1:0]   ar, dr, pc, ir, ac;
    logic [WIDTH-1:0]   regs [RDEPTH];
    logic               z_f, n_f, c_f;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    // Upper half accumulates partial sums, lower half holds the remaining
    // multiplier bits; after WIDTH shifts it holds the full product.
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [WIDTH:0]     psum;
    logic               last_iter;
    logic               mul_accept;

    logic               reg_valid;
    logic [WIDTH-1:0]   bus;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic [WIDTH:0]     alu_wide;

    assign reg_valid  = (32'(reg_sel) < NREGS);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign last_iter  = (state == RUN) && (count == CW'(WIDTH - 1));
    assign mul_accept = (state != RUN) && mul_start;

    assign bus_out  = bus;
    assign addr_out = ar;
    assign pc_addr  = pc;
    assign ir_out   = ir;
    assign flags    = {z_f, n_f, c_f};

    // Shared bus source mux.
    always_comb begin
        bus = '0;
        case (bus_sel)
            4'd1:    bus = ar;
            4'd2:    bus = pc;
            4'd3:    bus = ir;
            4'd4:    bus = dr;
            4'd5:    bus = reg_valid ? regs[reg_sel] : '0;
            4'd6:    bus = ac;
            4'd7:    bus = dram_in;
            4'd8:    bus = iram_in;
            default: bus = '0;
        endcase
    end

    // ALU: A = AC, B = bus, carry/borrow/shift-out into C.
    always_comb begin
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_wide = '0;
        case (alu_op)
            3'b000: alu_res = bus;
            3'b001: begin
                alu_wide = {1'b0, ac} + {1'b0, bus};
                alu_res  = alu_wide[WIDTH-1:0];
                alu_c    = alu_wide[WIDTH];
            end
            3'b010: begin
                alu_wide = {1'b0, ac} - {1'b0, bus};
                alu_res  = alu_wide[WIDTH-1:0];
                alu_c    = alu_wide[WIDTH];
            end
            3'b011: alu_res = ac & bus;
            3'b100: alu_res = ac | bus;
            3'b101: alu_res = ac ^ bus;
            3'b110: begin
                alu_res = {ac[WIDTH-2:0], 1'b0};
                alu_c   = ac[WIDTH-1];
            end
            default: begin
                alu_res = {1'b0, ac[WIDTH-1:1]};
                alu_c   = ac[0];
            end
        endcase
    end

    // One shift-add iteration of the multiplier.
    always_comb begin
        psum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_step = {psum, acc[WIDTH-1:1]};
    end

    // Multiplier next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mul_start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = mul_start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Multiplier state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Multiplier operand latch and iteration registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand <= '0;
            acc   <= '0;
            count <= '0;
        end else if (mul_accept) begin
            mcand <= ac;
            acc   <= {{WIDTH{1'b0}}, dr};
            count <= '0;
        end else if (state == RUN) begin
            acc   <= acc_step;
            count <= count + 1'b1;
        end
    end

    // Address, program counter and instruction registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ar <= '0;
            pc <= '0;
            ir <= '0;
        end else begin
            if (ld_ar)       ar <= bus;
            if (ld_ir)       ir <= bus;
            if (ld_pc)       pc <= bus;
            else if (inc_pc) pc <= pc + 1'b1;
        end
    end

    // General register file writes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < RDEPTH; i++) regs[i] <= '0;
        end else if (ld_r && reg_valid) begin
            regs[reg_sel] <= bus;
        end
    end

    // AC, DR and flags: multiply writeback owns them while busy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ac  <= '0;
            dr  <= '0;
            z_f <= 1'b0;
            n_f <= 1'b0;
            c_f <= 1'b0;
        end else if (last_iter) begin
            ac  <= acc_step[WIDTH-1:0];
            dr  <= acc_step[2*WIDTH-1:WIDTH];
            z_f <= (acc_step == '0);
            n_f <= acc_step[2*WIDTH-1];
            c_f <= |acc_step[2*WIDTH-1:WIDTH];
        end else if (!busy) begin
            if (alu_en) begin
                ac  <= alu_res;
                z_f <= (alu_res == '0);
                n_f <= alu_res[WIDTH-1];
                c_f <= alu_c;
            end else if (ld_ac) begin
                ac <= bus;
            end
            if (ld_dr) dr <= bus;
        end
    end

endmodule

// File: tb/tb_datapath_param.sv
// Directed bench for datapath_param with a queue scoreboard. Two instances
// share all inputs: a full 4-register build and a 2-register build used
// for the out-of-range register select cases.
module tb_datapath_param;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] dram_in, iram_in;
    logic [3:0]  bus_sel;
    logic [1:0]  reg_sel;
    logic        ld_ar, ld_dr, ld_r, ld_ac, ld_ir, ld_pc, inc_pc;
    logic        alu_en, mul_start;
    logic [2:0]  alu_op;

    logic [15:0] bus_out, addr_out, pc_addr, ir_out;
    logic [2:0]  flags;
    logic        busy, done;

    logic [15:0] b_bus_out, b_addr_out, b_pc_addr, b_ir_out;
    logic [2:0]  b_flags;
    logic        b_busy, b_done;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];

    datapath_param #(.WIDTH(16), .NREGS(4), .REG_AW(2)) dut (
        .clock(clock), .reset_n(reset_n), .dram_in(dram_in), .iram_in(iram_in),
        .bus_sel(bus_sel), .reg_sel(reg_sel), .ld_ar(ld_ar), .ld_dr(ld_dr),
        .ld_r(ld_r), .ld_ac(ld_ac), .ld_ir(ld_ir), .ld_pc(ld_pc), .inc_pc(inc_pc),
        .alu_en(alu_en), .alu_op(alu_op), .mul_start(mul_start),
        .bus_out(bus_out), .addr_out(addr_out), .pc_addr(pc_addr), .ir_out(ir_out),
        .flags(flags), .busy(busy), .done(done)
    );

    datapath_param #(.WIDTH(16), .NREGS(2), .REG_AW(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .dram_in(dram_in), .iram_in(iram_in),
        .bus_sel(bus_sel), .reg_sel(reg_sel), .ld_ar(ld_ar), .ld_dr(ld_dr),
        .ld_r(ld_r), .ld_ac(ld_ac), .ld_ir(ld_ir), .ld_pc(ld_pc), .inc_pc(inc_pc),
        .alu_en(alu_en), .alu_op(alu_op), .mul_start(mul_start),
        .bus_out(b_bus_out), .addr_out(b_addr_out), .pc_addr(b_pc_addr), .ir_out(b_ir_out),
        .flags(b_flags), .busy(b_busy), .done(b_done)
    );

    always #5 clock = ~clock;

    task automatic expect_v(input string tag, input logic [31:0] e);
        sb_t item;
        item.tag = tag;
        item.exp = e;
        sb.push_back(item);
    endtask

    task automatic check_v(input string tag, input logic [31:0] obs);
        sb_t item;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed %h with no expected entry queued", tag, obs);
        end else begin
            item = sb.pop_front();
            assert (item.tag == tag && obs === item.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h (queued as %s)", tag, obs, item.exp, item.tag);
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        bus_sel = 4'd0; reg_sel = 2'd0;
        ld_ar = 0; ld_dr = 0; ld_r = 0; ld_ac = 0; ld_ir = 0; ld_pc = 0;
        inc_pc = 0; alu_en = 0; alu_op = 3'b000; mul_start = 0;
    endtask

    task automatic load_from_dram(input logic [15:0] v, input bit to_ac, input bit to_dr);
        dram_in = v; bus_sel = 4'd7; ld_ac = to_ac; ld_dr = to_dr;
        step();
        clr();
    endtask

    task automatic alu_step(input logic [2:0] op, input logic [15:0] b);
        dram_in = b; bus_sel = 4'd7; alu_op = op; alu_en = 1;
        step();
        clr();
    endtask

    // Counts busy cycles until the multiplier drops busy (bounded). With
    // inject set it checks the live AC on the bus and issues ignored
    // commands partway through the run.
    task automatic wait_mul(input bit inject, input logic [15:0] live_ac, output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (inject && n == 3) begin
                bus_sel = 4'd6;
                #1;
                expect_v("live_ac", {16'h0, live_ac});
                check_v("live_ac", {16'h0, bus_out});
            end
            if (inject && n == 5) begin
                dram_in = 16'h1111; bus_sel = 4'd7;
                mul_start = 1; alu_en = 1; alu_op = 3'b001; ld_ac = 1; ld_dr = 1;
            end
            step();
            clr();
        end
    endtask

    task automatic read_ac_dr(input string tag, input logic [15:0] ac_e, input logic [15:0] dr_e);
        bus_sel = 4'd6; #1;
        expect_v({tag, "_ac"}, {16'h0, ac_e});
        check_v({tag, "_ac"}, {16'h0, bus_out});
        bus_sel = 4'd4; #1;
        expect_v({tag, "_dr"}, {16'h0, dr_e});
        check_v({tag, "_dr"}, {16'h0, bus_out});
        bus_sel = 4'd0;
    endtask

    initial begin
        int n;
        int pulses;
        logic [31:0] prod;

        reset_n = 1'b0;
        dram_in = '0; iram_in = '0;
        clr();
        repeat (2) step();

        // Reset state of both instances.
        expect_v("rst_state", 32'h0);
        check_v("rst_state", {addr_out, pc_addr});
        expect_v("rst_state2", 32'h0);
        check_v("rst_state2", {ir_out, 9'h0, flags, 2'b0, busy, done});
        expect_v("rst_state_b", 32'h0);
        check_v("rst_state_b", {b_addr_out ^ b_pc_addr ^ b_ir_out ^ b_bus_out, 9'h0, b_flags, 2'b0, b_busy, b_done});
        reset_n = 1'b1;

        // Random loads everywhere, then asynchronous reset mid-cycle.
        dram_in = 16'($urandom_range(1, 16'hFFFF)) | 16'h8000;
        bus_sel = 4'd7; ld_ar = 1; ld_pc = 1; ld_ir = 1; ld_ac = 1; ld_dr = 1;
        step(); clr();
        for (int i = 0; i < 4; i++) begin
            dram_in = 16'($urandom_range(1, 16'hFFFF)) | 16'h0001;
            bus_sel = 4'd7; reg_sel = 2'(i); ld_r = 1;
            step(); clr();
        end
        alu_step(3'b010, 16'hFFFF);
        #3 reset_n = 1'b0;
        #1;
        expect_v("async_rst", 32'h0);
        check_v("async_rst", {addr_out, pc_addr});
        expect_v("async_rst_ir_flags", 32'h0);
        check_v("async_rst_ir_flags", {ir_out, 9'h0, flags, 2'b0, busy, done});
        for (int i = 0; i < 4; i++) begin
            bus_sel = 4'd5; reg_sel = 2'(i); #1;
            expect_v("rst_reg", 32'h0);
            check_v("rst_reg", {16'h0, bus_out});
        end
        read_ac_dr("rst", 16'h0, 16'h0);
        clr();
        step();
        reset_n = 1'b1;

        // Bus sources and register loads.
        dram_in = 16'hBEEF; bus_sel = 4'd7; ld_ar = 1; ld_ir = 1; #1;
        expect_v("bus_dram", 32'hBEEF);
        check_v("bus_dram", {16'h0, bus_out});
        step(); clr();
        expect_v("ar_ir_load", 32'hBEEF_BEEF);
        check_v("ar_ir_load", {addr_out, ir_out});
        expect_v("ar_ir_load_b", 32'hBEEF_BEEF);
        check_v("ar_ir_load_b", {b_addr_out, b_ir_out});
        bus_sel = 4'd7; reg_sel = 2'd2; ld_r = 1;
        step(); clr();
        bus_sel = 4'd5; reg_sel = 2'd2; #1;
        expect_v("reg2_read", 32'hBEEF);
        check_v("reg2_read", {16'h0, bus_out});
        expect_v("reg2_oob_nregs2", 32'h0);
        check_v("reg2_oob_nregs2", {16'h0, b_bus_out});
        clr();
        dram_in = 16'h1357; bus_sel = 4'd7; reg_sel = 2'd1; ld_r = 1;
        step(); clr();
        bus_sel = 4'd5; reg_sel = 2'd1; #1;
        expect_v("reg1_both", 32'h1357_1357);
        check_v("reg1_both", {bus_out, b_bus_out});
        iram_in = 16'h5A5A; bus_sel = 4'd8; #1;
        expect_v("bus_iram", 32'h5A5A);
        check_v("bus_iram", {16'h0, bus_out});
        bus_sel = 4'd12; #1;
        expect_v("bus_unused_sel", 32'h0);
        check_v("bus_unused_sel", {16'h0, bus_out});
        clr();

        // Program counter load, wrap and priority.
        dram_in = 16'hFFFF; bus_sel = 4'd7; ld_pc = 1;
        step(); clr();
        expect_v("pc_load", 32'hFFFF);
        check_v("pc_load", {16'h0, pc_addr});
        inc_pc = 1;
        step(); clr();
        expect_v("pc_wrap", 32'h0);
        check_v("pc_wrap", {16'h0, pc_addr});
        dram_in = 16'h0040; bus_sel = 4'd7; ld_pc = 1; inc_pc = 1;
        step(); clr();
        expect_v("pc_ld_prio", 32'h0040);
        check_v("pc_ld_prio", {16'h0, pc_addr});

        // ALU results and flags {Z,N,C}.
        load_from_dram(16'hFFFF, 1, 0);
        alu_step(3'b001, 16'h0001);
        bus_sel = 4'd6; #1;
        expect_v("add_wrap", {16'h0000, 13'h0, 3'b101});
        check_v("add_wrap", {bus_out, 13'h0, flags});
        load_from_dram(16'h0003, 1, 0);
        expect_v("ld_ac_keeps_flags", 32'h5);
        check_v("ld_ac_keeps_flags", {29'h0, flags});
        alu_step(3'b010, 16'h0005);
        bus_sel = 4'd6; #1;
        expect_v("sub_borrow", {16'hFFFE, 13'h0, 3'b011});
        check_v("sub_borrow", {bus_out, 13'h0, flags});
        load_from_dram(16'h8001, 1, 0);
        alu_step(3'b111, 16'h0000);
        bus_sel = 4'd6; #1;
        expect_v("shr", {16'h4000, 13'h0, 3'b001});
        check_v("shr", {bus_out, 13'h0, flags});
        dram_in = 16'h00FF; bus_sel = 4'd7; alu_op = 3'b101; alu_en = 1; ld_ac = 1;
        step(); clr();
        bus_sel = 4'd6; #1;
        expect_v("alu_over_ld_ac", {16'h40FF, 13'h0, 3'b000});
        check_v("alu_over_ld_ac", {bus_out, 13'h0, flags});
        clr();

        // Multiply with ignored mid-run commands.
        load_from_dram(16'h1234, 1, 0);
        load_from_dram(16'h0100, 0, 1);
        prod = 32'h1234 * 32'h0100;
        mul_start = 1;
        step(); clr();
        wait_mul(1, 16'h1234, n);
        expect_v("mul_busy_cycles", 32'd16);
        check_v("mul_busy_cycles", 32'(n));
        expect_v("mul_done", 32'h1);
        check_v("mul_done", {31'h0, done});
        read_ac_dr("mul", prod[15:0], prod[31:16]);
        expect_v("mul_flags", 32'b001);
        check_v("mul_flags", {29'h0, flags});
        step();
        expect_v("mul_done_one_cycle", 32'h0);
        check_v("mul_done_one_cycle", {30'h0, busy, done});

        // Full-range multiply, then back-to-back start in the done cycle.
        load_from_dram(16'hFFFF, 1, 1);
        mul_start = 1;
        step(); clr();
        wait_mul(0, 16'h0, n);
        expect_v("mulmax_cycles", 32'd16);
        check_v("mulmax_cycles", 32'(n));
        read_ac_dr("mulmax", 16'h0001, 16'hFFFE);
        expect_v("mulmax_flags_done", {28'h0, 3'b011, 1'b1});
        check_v("mulmax_flags_done", {28'h0, flags, done});
        mul_start = 1;
        step(); clr();
        expect_v("b2b_busy", 32'h1);
        check_v("b2b_busy", {31'h0, busy});
        wait_mul(0, 16'h0, n);
        prod = 32'h0001 * 32'hFFFE;
        read_ac_dr("b2b", prod[15:0], prod[31:16]);
        expect_v("b2b_flags", 32'b000);
        check_v("b2b_flags", {29'h0, flags});
        step();

        // Reset during busy cycle 8 aborts without writeback.
        load_from_dram(16'h00FF, 1, 0);
        load_from_dram(16'h0F0F, 0, 1);
        mul_start = 1;
        step(); clr();
        repeat (7) step();
        expect_v("busy_before_abort", 32'h1);
        check_v("busy_before_abort", {31'h0, busy});
        #3 reset_n = 1'b0;
        #1;
        expect_v("abort_busy_done", 32'h0);
        check_v("abort_busy_done", {30'h0, busy, done});
        read_ac_dr("abort", 16'h0, 16'h0);
        step();
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) pulses++;
            step();
        end
        expect_v("abort_no_done", 32'h0);
        check_v("abort_no_done", 32'(pulses));

        expect_v("scoreboard_drained", 32'h0);
        check_v("scoreboard_drained", 32'(sb.size() - 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
